// File: rtl/arm_muldiv_if.sv
// arm_muldiv_if: issue/result bundle between the ARM controller and the multiply/divide unit.
//   master (controller): drives start, op, acc_en, a, b, acc_lo; observes busy, done, results, flags, div0.
//   slave  (unit):       observes the issue fields; drives busy, done, result_lo, result_hi, flags_nz, div0.
interface arm_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic             acc_en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc_lo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic [1:0]       flags_nz;
   logic             div0;
   modport master (
      output start, op, acc_en, a, b, acc_lo,
      input  busy, done, result_lo, result_hi, flags_nz, div0
   );
   modport slave (
      input  start, op, acc_en, a, b, acc_lo,
      output busy, done, result_lo, result_hi, flags_nz, div0
   );
endinterface

// File: rtl/arm_muldiv_unit.sv
// arm_muldiv_unit: iterative MUL/MLA/UMULL/SMULL/UDIV coprocessor with a fixed WIDTH+1 cycle latency.
//   clk, reset : clock and asynchronous active-high reset (aborts any operation in flight)
//   bus        : slave side of arm_muldiv_if (start/op/acc_en/a/b/acc_lo in; busy/done/results/flags/div0 out)
module arm_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         reset,
   arm_muldiv_if.slave bus
);
   localparam int CNTW = $clog2(WIDTH) + 1;
   localparam logic [1:0] OP_MUL = 2'b00, OP_UMULL = 2'b01, OP_SMULL = 2'b10, OP_UDIV = 2'b11;
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t             state, state_nx;
   logic [1:0]         op_r;
   logic               acc_en_r, neg_r, is_div, is_long, last, ge;
   logic [WIDTH-1:0]   m_r, acc_r, hi, lo, mag_a, mag_b, diff, res_lo, res_hi;
   logic [WIDTH:0]     sum, shifted;
   logic [2*WIDTH-1:0] work, work_nx, prod;
   logic [CNTW-1:0]    cnt;
   assign is_div  = op_r == OP_UDIV;
   assign is_long = op_r == OP_UMULL || op_r == OP_SMULL;
   assign last    = cnt == CNTW'(WIDTH - 1);
   assign hi      = work[2*WIDTH-1:WIDTH];
   assign lo      = work[WIDTH-1:0];
   // SMULL multiplies magnitudes; the most negative value negates to itself, which is its correct unsigned magnitude
   assign mag_a   = (bus.op == OP_SMULL && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign mag_b   = (bus.op == OP_SMULL && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   // Multiply: work = {partial, multiplier}; add multiplicand on lo[0], then shift right with the carry.
   // Divide: work = {remainder, dividend/quotient}; shift one dividend bit into the remainder, subtract if it fits.
   // With b==0 every step subtracts zero, giving an all-ones quotient and the dividend as remainder.
   assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, m_r} : '0);
   assign shifted = {hi, lo[WIDTH-1]};
   assign ge      = shifted >= {1'b0, m_r};
   assign diff    = shifted[WIDTH-1:0] - m_r;
   assign work_nx = is_div ? (ge ? {diff, lo[WIDTH-2:0], 1'b1} : {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0})
                           : {sum, lo[WIDTH-1:1]};
   assign prod    = neg_r ? -work_nx : work_nx;
   assign res_lo  = op_r == OP_MUL ? work_nx[WIDTH-1:0] + (acc_en_r ? acc_r : '0) : prod[WIDTH-1:0];
   assign res_hi  = op_r == OP_MUL ? '0 : prod[2*WIDTH-1:WIDTH];
   assign bus.busy = state != IDLE;
   assign bus.done = state == FIN;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? FIN : RUN) : IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         op_r          <= '0;
         acc_en_r      <= 1'b0;
         neg_r         <= 1'b0;
         m_r           <= '0;
         acc_r         <= '0;
         work          <= '0;
         cnt           <= '0;
         bus.result_lo <= '0;
         bus.result_hi <= '0;
         bus.flags_nz  <= '0;
         bus.div0      <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         op_r     <= bus.op;
         acc_en_r <= bus.acc_en;
         neg_r    <= bus.op == OP_SMULL && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         m_r      <= bus.op == OP_UDIV ? bus.b : mag_a;
         acc_r    <= bus.acc_lo;
         work     <= {{WIDTH{1'b0}}, bus.op == OP_UDIV ? bus.a : mag_b};
         cnt      <= '0;
      end else if (state == RUN) begin
         work <= work_nx;
         cnt  <= cnt + CNTW'(1);
         // results are registered on the last iteration so they are valid during the FIN (done) cycle
         if (last) begin
            bus.result_lo <= res_lo;
            bus.result_hi <= res_hi;
            bus.flags_nz  <= {is_long ? res_hi[WIDTH-1] : res_lo[WIDTH-1], res_lo == '0 && (!is_long || res_hi == '0)};
            bus.div0      <= is_div && m_r == '0;
         end
      end
endmodule

// File: tb/tb_arm_muldiv_unit.sv
// tb_arm_muldiv_unit: directed scoreboard bench for arm_muldiv_unit (WIDTH=32).
//   Drives the master side of arm_muldiv_if; expected results come from a 64-bit reference model.
module tb_arm_muldiv_unit;
   localparam int W = 32;
   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [1:0]  nz;
      logic        d0;
   } exp_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_lo = '0;
   exp_t        sb[$];
   arm_muldiv_if #(.WIDTH(W)) bus();
   arm_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic exp_t model(input logic [1:0] op, input logic ae, input logic [31:0] a, b, acc);
      exp_t        e;
      logic [63:0] p;
      logic [31:0] m;
      logic        lng;
      m   = a * b + (ae ? acc : 32'd0);
      lng = op == 2'b01 || op == 2'b10;
      p   = op == 2'b00 ? {32'd0, m}
          : op == 2'b01 ? {32'd0, a} * {32'd0, b}
          : op == 2'b10 ? 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}))
          : (b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b});
      e.lo = p[31:0];
      e.hi = p[63:32];
      e.nz = {lng ? p[63] : p[31], p[31:0] == 0 && (!lng || p[63:32] == 0)};
      e.d0 = op == 2'b11 && b == 0;
      return e;
   endfunction
   task automatic start_op(input logic [1:0] op, input logic ae, input logic [31:0] a, b, acc);
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      bus.op = op; bus.acc_en = ae; bus.a = a; bus.b = b; bus.acc_lo = acc; bus.start = 1'b1;
      sb.push_back(model(op, ae, a, b, acc));
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   // Entered at the negedge of cycle 1; poke>0 pulses a conflicting start in that cycle.
   task automatic finish_op(input int poke);
      exp_t e;
      bit   got = 0;
      for (int k = 1; k <= W + 10 && !got; k++) begin
         if (k == poke) begin
            bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd77; bus.b = 32'd3;
         end
         if (k == poke + 1) bus.start = 1'b0;
         if (k == W / 2) chk("hold_lo", bus.result_lo, last_lo);
         if (bus.done) begin
            got = 1;
            chk("latency", k, W + 1);
            chk("busy_at_done", bus.busy, 1);
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("result_lo", bus.result_lo, e.lo);
               chk("result_hi", bus.result_hi, e.hi);
               chk("flags_nz", bus.flags_nz, e.nz);
               chk("div0", bus.div0, e.d0);
            end
            last_lo = bus.result_lo;
         end else begin
            chk("busy_run", bus.busy, 1);
            @(negedge clk);
         end
      end
      if (!got) chk("done_timeout", 0, 1);
   endtask
   initial begin
      int seen;
      bus.start = 1'b0; bus.op = '0; bus.acc_en = 1'b0; bus.a = '0; bus.b = '0; bus.acc_lo = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_lo", bus.result_lo, 0);
      chk("rst_hi", bus.result_hi, 0);
      chk("rst_nz", bus.flags_nz, 0);
      chk("rst_div0", bus.div0, 0);
      reset = 1'b0;
      start_op(2'b00, 1'b0, 32'd7, 32'd6, 32'd0);
      finish_op(0);
      chk("mul_42", bus.result_lo, 42);
      start_op(2'b00, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd3);
      finish_op(0);
      chk("mla_1", bus.result_lo, 1);
      start_op(2'b10, 1'b0, -32'sd3, 32'd5, 32'd0);
      finish_op(0);
      chk("smull_neg", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      start_op(2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9);
      finish_op(0);
      chk("umull_max", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFE_0000_0001);
      start_op(2'b10, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0);
      finish_op(0);
      chk("smull_minmin", {bus.result_hi, bus.result_lo}, 64'h4000_0000_0000_0000);
      start_op(2'b11, 1'b0, 32'd100, 32'd7, 32'd0);
      finish_op(0);
      chk("udiv_100_7", {bus.result_hi, bus.result_lo}, {32'd2, 32'd14});
      start_op(2'b11, 1'b0, 32'd5, 32'd0, 32'd0);
      finish_op(0);
      chk("udiv_by0", bus.div0, 1);
      start_op(2'b00, 1'b0, 32'd0, 32'd9, 32'd0);
      finish_op(0);
      chk("mul0_flags", {bus.div0, bus.flags_nz}, 3'b001);
      start_op(2'b00, 1'b0, 32'd123, 32'd456, 32'd0);
      finish_op(10);
      @(negedge clk);
      chk("no_second_done", bus.done, 0);
      start_op(2'b00, 1'b0, 32'd5, 32'd5, 32'd0);
      finish_op(0);
      for (int i = 0; i < 4; i++) begin
         start_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, $urandom);
         finish_op(0);
      end
      start_op(2'b11, 1'b0, 32'd1000, 32'd3, 32'd0);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_lo", bus.result_lo, 0);
      chk("abort_hi", bus.result_hi, 0);
      chk("abort_nz", bus.flags_nz, 0);
      chk("abort_div0", bus.div0, 0);
      sb.delete();
      last_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < W + 8; k++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("abort_no_done", seen, 0);
      start_op(2'b00, 1'b0, 32'd3, 32'd3, 32'd0);
      finish_op(0);
      chk("mul_9", bus.result_lo, 9);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
